// File: rtl/semaforo_pkg.sv
// Shared definitions for the two-street traffic light scheduler.
// Holds the state encoding, the next-green side selector, the lamp patterns
// ({red, yellow, green}) and the state-to-lamp decode used by the top level.
package semaforo_pkg;

  typedef enum logic [2:0] {
    S_AG   = 3'd0,
    S_AY   = 3'd1,
    S_AR   = 3'd2,
    S_BG   = 3'd3,
    S_BY   = 3'd4,
    S_BR   = 3'd5,
    S_WALK = 3'd6
  } state_t;

  typedef enum logic {
    SIDE_A = 1'b0,
    SIDE_B = 1'b1
  } side_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  // Returns {LA, LB} for a state; every non-green/yellow state is all-red.
  function automatic logic [5:0] lamps_of(state_t s);
    case (s)
      S_AG:    lamps_of = {GRN, RED};
      S_AY:    lamps_of = {YEL, RED};
      S_BG:    lamps_of = {RED, GRN};
      S_BY:    lamps_of = {RED, YEL};
      default: lamps_of = {RED, RED};
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Timing-tick generator.
// Counts board clocks 0..TICK_DIV-1 and raises tick for the single clock in
// which the count wraps, so the first tick appears TICK_DIV clocks after
// reset is released.
// Ports: clk (board clock), reset (sync, active-low), tick (registered strobe).
module tick_prescaler
  import semaforo_pkg::*;
#(
  parameter int TICK_DIV = 16000000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d  = cnt_q + 1'b1;
      tick_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/semaforo_scheduler.sv
// Two-street (A/B) traffic light sequencer with pedestrian WALK phase and
// parade mode. All state changes happen on timing ticks; elapsed counts the
// ticks spent in the current state and saturates.
// Ports:
//   clk, reset      board clock, synchronous active-low reset
//   TA, TB          traffic present on street A / B (active-high)
//   P, R            parade set / clear (clear wins)
//   ped_req         pedestrian request (rising edge latches a request)
//   ped_ack         one-clock pulse when a WALK phase starts
//   LA, LB          lamps {red, yellow, green} for street A / B
//   walk            pedestrian WALK lamp
//   tick            timing strobe
//   state           current state code (debug)
module semaforo_scheduler
  import semaforo_pkg::*;
#(
  parameter int TICK_DIV  = 16000000,
  parameter int GREEN_MIN = 5,
  parameter int GREEN_MAX = 15,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       TA,
  input  logic       TB,
  input  logic       P,
  input  logic       R,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic [2:0] LA,
  output logic [2:0] LB,
  output logic       walk,
  output logic       tick,
  output logic [2:0] state
);

  localparam int EL_W = $clog2(GREEN_MAX + 1);

  state_t          state_q, state_d;
  logic [EL_W-1:0] elapsed_q, elapsed_d;
  side_t           next_side_q, next_side_d;
  logic            parade_q, parade_d;
  logic            ped_pend_q, ped_pend_d;
  logic            ped_req_prev_q, ped_req_prev_d;
  logic            ped_ack_q, ped_ack_d;
  logic            walk_q, walk_d;
  logic [2:0]      la_q, la_d, lb_q, lb_d;

  logic            tick_w;
  logic [31:0]     e_inc;
  logic            adv, illegal, enter_walk, ped_rise;
  logic            a_green_done, b_green_done;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick_w)
  );

  always_comb begin
    // Exit tests look at the tick count including the tick now being taken.
    e_inc = 32'(elapsed_q) + 32'd1;
    a_green_done = ((e_inc >= 32'(GREEN_MIN)) && (!TA || ped_pend_q)) ||
                   (e_inc >= 32'(GREEN_MAX));
    // Parade freezes B green regardless of traffic or pedestrians.
    b_green_done = !parade_q &&
                   (((e_inc >= 32'(GREEN_MIN)) && (!TB || ped_pend_q)) ||
                    (e_inc >= 32'(GREEN_MAX)));

    state_d     = state_q;
    next_side_d = next_side_q;
    adv         = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      S_AG: if (tick_w && a_green_done) begin
        state_d = S_AY;
        adv     = 1'b1;
      end
      S_AY: if (tick_w && (e_inc >= 32'(YELLOW_T))) begin
        state_d     = S_AR;
        next_side_d = SIDE_B;
        adv         = 1'b1;
      end
      S_AR: if (tick_w && (e_inc >= 32'(ALLRED_T))) begin
        state_d = (ped_pend_q && !parade_q) ? S_WALK : S_BG;
        adv     = 1'b1;
      end
      S_BG: if (tick_w && b_green_done) begin
        state_d = S_BY;
        adv     = 1'b1;
      end
      S_BY: if (tick_w && (e_inc >= 32'(YELLOW_T))) begin
        state_d     = S_BR;
        next_side_d = SIDE_A;
        adv         = 1'b1;
      end
      S_BR: if (tick_w && (e_inc >= 32'(ALLRED_T))) begin
        state_d = (ped_pend_q && !parade_q) ? S_WALK : S_AG;
        adv     = 1'b1;
      end
      S_WALK: if (tick_w && (e_inc >= 32'(WALK_T))) begin
        state_d = (next_side_q == SIDE_A) ? S_AG : S_BG;
        adv     = 1'b1;
      end
      default: begin
        // Unused code: recover to A green immediately, not on a tick.
        state_d = S_AG;
        illegal = 1'b1;
      end
    endcase

    if (adv || illegal) begin
      elapsed_d = '0;
    end else if (tick_w && (elapsed_q != '1)) begin
      elapsed_d = elapsed_q + 1'b1;
    end else begin
      elapsed_d = elapsed_q;
    end

    enter_walk     = adv && (state_d == S_WALK);
    ped_rise       = ped_req && !ped_req_prev_q;
    ped_req_prev_d = ped_req;

    // Entering WALK serves the request; edges seen while walking are dropped.
    if (enter_walk) begin
      ped_pend_d = 1'b0;
    end else if (ped_rise && (state_q != S_WALK)) begin
      ped_pend_d = 1'b1;
    end else begin
      ped_pend_d = ped_pend_q;
    end

    if (R) begin
      parade_d = 1'b0;
    end else if (P) begin
      parade_d = 1'b1;
    end else begin
      parade_d = parade_q;
    end

    {la_d, lb_d} = lamps_of(state_d);
    walk_d       = (state_d == S_WALK);
    ped_ack_d    = enter_walk;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= S_AG;
      elapsed_q      <= '0;
      next_side_q    <= SIDE_B;
      parade_q       <= 1'b0;
      ped_pend_q     <= 1'b0;
      ped_req_prev_q <= 1'b0;
      ped_ack_q      <= 1'b0;
      walk_q         <= 1'b0;
      la_q           <= GRN;
      lb_q           <= RED;
    end else begin
      state_q        <= state_d;
      elapsed_q      <= elapsed_d;
      next_side_q    <= next_side_d;
      parade_q       <= parade_d;
      ped_pend_q     <= ped_pend_d;
      ped_req_prev_q <= ped_req_prev_d;
      ped_ack_q      <= ped_ack_d;
      walk_q         <= walk_d;
      la_q           <= la_d;
      lb_q           <= lb_d;
    end
  end

  assign LA      = la_q;
  assign LB      = lb_q;
  assign walk    = walk_q;
  assign ped_ack = ped_ack_q;
  assign tick    = tick_w;
  assign state   = state_q;

endmodule

// File: tb/tb_semaforo_scheduler.sv
module tb_semaforo_scheduler;

  localparam int TD    = 4;
  localparam int GMIN  = 2;
  localparam int GMAX  = 5;
  localparam int YT    = 1;
  localparam int ART   = 1;
  localparam int WT    = 2;
  localparam int EL_MAX = (1 << $clog2(GMAX + 1)) - 1;

  logic       clk;
  logic       reset;
  logic       TA, TB, P, R, ped_req;
  logic       ped_ack, walk, tick;
  logic [2:0] la, lb, dut_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state (spec-level quantities)
  int m_state = 0;
  int m_el    = 0;
  int m_par   = 0;
  int m_pend  = 0;
  int m_prev  = 0;
  int m_side  = 1;
  int m_since = 0;
  int m_tick  = 0;
  int m_ack   = 0;

  semaforo_scheduler #(
    .TICK_DIV (TD),
    .GREEN_MIN(GMIN),
    .GREEN_MAX(GMAX),
    .YELLOW_T (YT),
    .ALLRED_T (ART),
    .WALK_T   (WT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .TA     (TA),
    .TB     (TB),
    .P      (P),
    .R      (R),
    .ped_req(ped_req),
    .ped_ack(ped_ack),
    .LA     (la),
    .LB     (lb),
    .walk   (walk),
    .tick   (tick),
    .state  (dut_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int lamp_a(input int s);
    if (s == 0) return 1;
    if (s == 1) return 2;
    return 4;
  endfunction

  function automatic int lamp_b(input int s);
    if (s == 3) return 1;
    if (s == 4) return 2;
    return 4;
  endfunction

  // Advance the reference by one clock using the inputs currently applied.
  task automatic model_step();
    int e, nxt, side_n;
    bit rise;
    if (!reset) begin
      m_state = 0; m_el = 0; m_par = 0; m_pend = 0; m_prev = 0;
      m_side = 1; m_since = 0; m_tick = 0; m_ack = 0;
      return;
    end
    e = m_el + 1;
    nxt = m_state;
    side_n = m_side;
    if (m_tick != 0) begin
      case (m_state)
        0: if ((e >= GMIN && (!TA || m_pend != 0)) || e >= GMAX) nxt = 1;
        1: if (e >= YT) begin nxt = 2; side_n = 1; end
        2: if (e >= ART) nxt = (m_pend != 0 && m_par == 0) ? 6 : 3;
        3: if (m_par == 0 && ((e >= GMIN && (!TB || m_pend != 0)) || e >= GMAX)) nxt = 4;
        4: if (e >= YT) begin nxt = 5; side_n = 0; end
        5: if (e >= ART) nxt = (m_pend != 0 && m_par == 0) ? 6 : 0;
        default: if (e >= WT) nxt = (m_side == 1) ? 3 : 0;
      endcase
    end
    rise = ped_req && (m_prev == 0);
    m_ack = (nxt == 6 && m_state != 6) ? 1 : 0;
    if (m_ack != 0) m_pend = 0;
    else if (rise && m_state != 6) m_pend = 1;
    if (nxt != m_state) m_el = 0;
    else if (m_tick != 0 && m_el < EL_MAX) m_el++;
    m_state = nxt;
    m_side = side_n;
    if (R) m_par = 0;
    else if (P) m_par = 1;
    m_prev = ped_req ? 1 : 0;
    m_since++;
    m_tick = (m_since % TD == 0) ? 1 : 0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (reset) cyc++;
    else cyc = 0;
    chk("la", 32'(la), 32'(lamp_a(m_state)));
    chk("lb", 32'(lb), 32'(lamp_b(m_state)));
    chk("walk", 32'(walk), (m_state == 6) ? 32'd1 : 32'd0);
    chk("ped_ack", 32'(ped_ack), 32'(m_ack));
    chk("tick", 32'(tick), 32'(m_tick));
    chk("state", 32'(dut_state), 32'(m_state));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) cycle();
    reset = 1'b1;
  endtask

  task automatic wait_state(input int s, input int limit);
    while (dut_state != 3'(s) && cyc < limit) cycle();
  endtask

  initial begin
    int held, walks;
    reset = 1'b0; TA = 1'b0; TB = 1'b0; P = 1'b0; R = 1'b0; ped_req = 1'b0;

    // Reset values and first tick position
    do_reset(3);
    chk("rst_la", 32'(la), 32'd1);
    chk("rst_lb", 32'(lb), 32'd4);
    chk("rst_walk", 32'(walk), 32'd0);
    chk("rst_state", 32'(dut_state), 32'd0);
    chk("rst_ack", 32'(ped_ack), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    while (!tick && cyc < 10) cycle();
    chk("t1_first_tick", 32'(cyc), 32'd4);
    cycle();
    chk("t1_tick_width", 32'(tick), 32'd0);

    // Full A green with traffic on both streets
    TA = 1'b1; TB = 1'b1;
    do_reset(2);
    wait_state(1, 40);
    chk("t2_ay_entry", 32'(cyc), 32'd21);
    chk("t2_la_yel", 32'(la), 32'd2);
    wait_state(2, 50);
    chk("t2_ar_entry", 32'(cyc), 32'd25);
    chk("t2_ar_la", 32'(la), 32'd4);
    chk("t2_ar_lb", 32'(lb), 32'd4);
    wait_state(3, 60);
    chk("t2_bg_entry", 32'(cyc), 32'd29);
    chk("t2_lb_grn", 32'(lb), 32'd1);

    // No traffic: minimum green on both sides
    TA = 1'b0; TB = 1'b0;
    do_reset(2);
    wait_state(1, 30);
    chk("t3_ay_entry", 32'(cyc), 32'd9);
    wait_state(3, 40);
    chk("t3_bg_entry", 32'(cyc), 32'd17);
    wait_state(4, 50);
    chk("t3_by_entry", 32'(cyc), 32'd25);

    // Pedestrian request cuts A green short and gets a WALK
    TA = 1'b1; TB = 1'b1;
    do_reset(2);
    cycle();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    wait_state(1, 30);
    chk("t4_ay_entry", 32'(cyc), 32'd9);
    wait_state(6, 40);
    chk("t4_walk_entry", 32'(cyc), 32'd17);
    chk("t4_walk_lamp", 32'(walk), 32'd1);
    chk("t4_walk_la", 32'(la), 32'd4);
    chk("t4_walk_lb", 32'(lb), 32'd4);
    chk("t4_ack_on", 32'(ped_ack), 32'd1);
    cycle();
    chk("t4_ack_off", 32'(ped_ack), 32'd0);
    wait_state(3, 40);
    chk("t4_bg_after_walk", 32'(cyc), 32'd25);
    chk("t4_lb_grn", 32'(lb), 32'd1);

    // Parade holds B green; pedestrian waits until parade is cleared
    TA = 1'b1; TB = 1'b0;
    do_reset(2);
    cycle();
    P = 1'b1;
    cycle();
    P = 1'b0;
    wait_state(3, 40);
    chk("t5_bg_entry", 32'(cyc), 32'd29);
    held = 0; walks = 0;
    for (int i = 0; i < 200; i++) begin
      ped_req = (i == 50);
      cycle();
      if (dut_state == 3'd3) held++;
      if (walk) walks++;
    end
    ped_req = 1'b0;
    chk("t5_bg_held", 32'(held), 32'd200);
    chk("t5_no_walk", 32'(walks), 32'd0);
    R = 1'b1;
    cycle();
    R = 1'b0;
    wait_state(4, 250);
    chk("t5_by_after_clear", 32'(cyc), 32'd233);
    wait_state(6, 260);
    chk("t5_walk_served", 32'(cyc), 32'd241);

    // P and R together leave parade off
    TA = 1'b1; TB = 1'b0;
    do_reset(2);
    cycle();
    P = 1'b1; R = 1'b1;
    cycle();
    P = 1'b0; R = 1'b0;
    wait_state(3, 40);
    chk("t5b_bg_entry", 32'(cyc), 32'd29);
    wait_state(4, 50);
    chk("t5b_by_entry", 32'(cyc), 32'd37);

    // Reset during WALK drops the served/pending request
    TA = 1'b0; TB = 1'b1;
    do_reset(2);
    cycle();
    ped_req = 1'b1;
    cycle();
    ped_req = 1'b0;
    wait_state(6, 30);
    chk("t6_walk_entry", 32'(cyc), 32'd17);
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("t6_rst_la", 32'(la), 32'd1);
    chk("t6_rst_lb", 32'(lb), 32'd4);
    chk("t6_rst_walk", 32'(walk), 32'd0);
    reset = 1'b1;
    wait_state(3, 40);
    chk("t6_bg_no_walk", 32'(cyc), 32'd17);

    // Randomized traffic, requests, parade and occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(15) == 0) TA = ~TA;
      if ($urandom_range(15) == 0) TB = ~TB;
      ped_req = ($urandom_range(24) == 0);
      P = ($urandom_range(150) == 0);
      R = ($urandom_range(120) == 0);
      reset = !($urandom_range(700) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
